// File: rtl/mandelbrot_pkg.sv
// Shared types and constants for the Mandelbrot/Julia iteration engine.
// Fixed point is signed 2.FRAC, so ONE is the raw encoding of 1.0.
package mandelbrot_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int FRAC      = DEF_WIDTH - 2;
    localparam int ONE       = 1 << FRAC;

    localparam logic MODE_MANDEL = 1'b0;
    localparam logic MODE_JULIA  = 1'b1;

endpackage

// File: rtl/mandelbrot_step.sv
// One combinational z <- z^2 + c step with escape-size and fixed-point overflow detection.
// Products are full precision; the sum carries two guard bits above the 2W product.
module mandelbrot_step #(
    parameter int WIDTH         = 8,
    parameter int ESC_RADIUS_SQ = 4
) (
    input  logic signed [WIDTH-1:0] i_cr,
    input  logic signed [WIDTH-1:0] i_ci,
    input  logic signed [WIDTH-1:0] i_zr,
    input  logic signed [WIDTH-1:0] i_zi,
    output logic signed [WIDTH-1:0] o_zr_next,
    output logic signed [WIDTH-1:0] o_zi_next,
    output logic                    o_size_exceeded,
    output logic                    o_overflow
);
    localparam int PW = 2 * WIDTH;
    localparam int GW = PW + 2;
    localparam int FR = WIDTH - 2;
    localparam logic [PW:0] ESC_TH = (PW + 1)'(ESC_RADIUS_SQ) << (PW - 4);

    logic signed [PW-1:0] w_zr_x, w_zi_x;
    logic signed [PW-1:0] w_zr_sq, w_zi_sq, w_cross;
    logic signed [GW-1:0] w_cr_al, w_ci_al, w_sum_r, w_sum_i;
    logic        [PW:0]   w_mag;

    assign w_zr_x  = {{WIDTH{i_zr[WIDTH-1]}}, i_zr};
    assign w_zi_x  = {{WIDTH{i_zi[WIDTH-1]}}, i_zi};
    assign w_zr_sq = w_zr_x * w_zr_x;
    assign w_zi_sq = w_zi_x * w_zi_x;
    assign w_cross = w_zr_x * w_zi_x;

    // c moved onto the product scale (2.FR * 2.FR -> 4.2FR)
    assign w_cr_al = {{(GW - WIDTH - FR){i_cr[WIDTH-1]}}, i_cr, {FR{1'b0}}};
    assign w_ci_al = {{(GW - WIDTH - FR){i_ci[WIDTH-1]}}, i_ci, {FR{1'b0}}};

    assign w_sum_r = {{2{w_zr_sq[PW-1]}}, w_zr_sq} - {{2{w_zi_sq[PW-1]}}, w_zi_sq} + w_cr_al;
    assign w_sum_i = {w_cross[PW-1], w_cross, 1'b0} + w_ci_al;

    assign o_zr_next = w_sum_r[PW-3:FR];
    assign o_zi_next = w_sum_i[PW-3:FR];

    // Everything above the kept field must be a copy of its sign bit
    assign o_overflow = (~&w_sum_r[GW-1:PW-3] & |w_sum_r[GW-1:PW-3])
                      | (~&w_sum_i[GW-1:PW-3] & |w_sum_i[GW-1:PW-3]);

    assign w_mag           = {1'b0, w_zr_sq} + {1'b0, w_zi_sq};
    assign o_size_exceeded = (w_mag > ESC_TH);

endmodule

// File: rtl/mandelbrot_iter_engine.sv
// Per-pixel escape-time engine: one iteration per clock, valid/ready on both sides.
// Latency accept->out_valid = decision k + 2; result held in DONE until out_ready.
module mandelbrot_iter_engine
    import mandelbrot_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int ITER_WIDTH    = 8,
    parameter int ESC_RADIUS_SQ = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      pixel_r,
    input  logic [WIDTH-1:0]      pixel_i,
    input  logic [WIDTH-1:0]      julia_cr,
    input  logic [WIDTH-1:0]      julia_ci,
    input  logic [ITER_WIDTH-1:0] max_iter,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ITER_WIDTH-1:0] out_iter,
    output logic                  out_escaped,
    output logic                  out_overflow
);
    state_t                  r_state;
    logic signed [WIDTH-1:0] r_zr, r_zi, r_cr, r_ci;
    logic [ITER_WIDTH-1:0]   r_k, r_max_iter, r_out_iter;
    logic                    r_out_vld, r_out_esc, r_out_ovf;

    logic signed [WIDTH-1:0] w_zr_next, w_zi_next;
    logic                    w_size, w_ovf;

    mandelbrot_step #(
        .WIDTH         (WIDTH),
        .ESC_RADIUS_SQ (ESC_RADIUS_SQ)
    ) u_step (
        .i_cr            (r_cr),
        .i_ci            (r_ci),
        .i_zr            (r_zr),
        .i_zi            (r_zi),
        .o_zr_next       (w_zr_next),
        .o_zi_next       (w_zi_next),
        .o_size_exceeded (w_size),
        .o_overflow      (w_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_zr       <= '0;
            r_zi       <= '0;
            r_cr       <= '0;
            r_ci       <= '0;
            r_k        <= '0;
            r_max_iter <= '0;
            r_out_vld  <= 1'b0;
            r_out_iter <= '0;
            r_out_esc  <= 1'b0;
            r_out_ovf  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (mode == MODE_JULIA) begin
                            r_cr <= julia_cr;
                            r_ci <= julia_ci;
                            r_zr <= pixel_r;
                            r_zi <= pixel_i;
                        end else begin
                            r_cr <= pixel_r;
                            r_ci <= pixel_i;
                            r_zr <= '0;
                            r_zi <= '0;
                        end
                        r_max_iter <= max_iter;
                        r_k        <= '0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    if (w_size) begin
                        r_state    <= DONE;
                        r_out_vld  <= 1'b1;
                        r_out_iter <= r_k;
                        r_out_esc  <= 1'b1;
                        r_out_ovf  <= 1'b0;
                    end else if (r_k == r_max_iter) begin
                        r_state    <= DONE;
                        r_out_vld  <= 1'b1;
                        r_out_iter <= r_k;
                        r_out_esc  <= 1'b0;
                        r_out_ovf  <= 1'b0;
                    end else if (w_ovf) begin
                        // Overflow on z_{k+1} counts as escaping on that iteration
                        r_state    <= DONE;
                        r_out_vld  <= 1'b1;
                        r_out_iter <= r_k + 1'b1;
                        r_out_esc  <= 1'b1;
                        r_out_ovf  <= 1'b1;
                    end else begin
                        r_zr <= w_zr_next;
                        r_zi <= w_zi_next;
                        r_k  <= r_k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state   <= IDLE;
                        r_out_vld <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready     = (r_state == IDLE);
    assign out_valid    = r_out_vld;
    assign out_iter     = r_out_iter;
    assign out_escaped  = r_out_esc;
    assign out_overflow = r_out_ovf;

endmodule

// File: tb/tb_mandelbrot_iter_engine.sv
// Directed vector bench for mandelbrot_iter_engine (WIDTH=8, 1.0 = 64).
module tb_mandelbrot_iter_engine;
    import mandelbrot_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] pixel_r = '0, pixel_i = '0, julia_cr = '0, julia_ci = '0, max_iter = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_iter;
    logic       out_escaped, out_overflow;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    mandelbrot_iter_engine #(.WIDTH(8), .ITER_WIDTH(8), .ESC_RADIUS_SQ(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode         (mode),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pixel_r      (pixel_r),
        .pixel_i      (pixel_i),
        .julia_cr     (julia_cr),
        .julia_ci     (julia_ci),
        .max_iter     (max_iter),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_iter     (out_iter),
        .out_escaped  (out_escaped),
        .out_overflow (out_overflow)
    );

    typedef struct {
        logic       mode;
        logic [7:0] pr, pi, jcr, jci, mi;
        logic [7:0] e_iter;
        logic       e_esc, e_ovf;
        int         e_lat;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Presents one request, waits (bounded) for out_valid, returns latency without consuming the result.
    task automatic request(input vec_t v, output int lat);
        mode     = v.mode;
        pixel_r  = v.pr;
        pixel_i  = v.pi;
        julia_cr = v.jcr;
        julia_ci = v.jci;
        max_iter = v.mi;
        in_valid = 1'b1;
        chk("accept_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        vecs[0] = '{MODE_MANDEL, 8'd0,   8'd0,  8'd0,  8'd0,   8'd20, 8'd20, 1'b0, 1'b0, 22};
        vecs[1] = '{MODE_MANDEL, 8'(ONE), 8'd0, 8'd0,  8'd0,   8'd50, 8'd2,  1'b1, 1'b1, 3};
        vecs[2] = '{MODE_MANDEL, 8'd0,   8'(ONE), 8'd0, 8'd0,  8'd15, 8'd15, 1'b0, 1'b0, 17};
        vecs[3] = '{MODE_JULIA,  8'd96,  8'd96, 8'd0,  8'd0,   8'd10, 8'd0,  1'b1, 1'b0, 2};
        vecs[4] = '{MODE_JULIA,  8'd96,  8'd0,  8'd0,  8'd0,   8'd10, 8'd1,  1'b1, 1'b1, 2};
        vecs[5] = '{MODE_MANDEL, 8'd0,   8'd0,  8'd0,  8'd0,   8'd0,  8'd0,  1'b0, 1'b0, 2};
        // c = -2: |z1|^2 is exactly 4 (not escaping), z2 = +2 overflows
        vecs[6] = '{MODE_MANDEL, 8'h80,  8'd0,  8'd0,  8'd0,   8'd10, 8'd2,  1'b1, 1'b1, 3};
        // Julia c = 0.5: z = 0, 32, 48, 68 -> limit reached at k = 3
        vecs[7] = '{MODE_JULIA,  8'd0,   8'd0,  8'd32, 8'd0,   8'd3,  8'd3,  1'b0, 1'b0, 5};
        vecs[8] = '{MODE_JULIA,  8'd0,   8'd0,  8'd0,  8'hE0,  8'd2,  8'd2,  1'b0, 1'b0, 4};

        #12;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_iter", int'(out_iter), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            request(vecs[i], lat);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].e_lat);
            chk($sformatf("v%0d_iter", i), int'(out_iter), int'(vecs[i].e_iter));
            chk($sformatf("v%0d_escaped", i), int'(out_escaped), int'(vecs[i].e_esc));
            chk($sformatf("v%0d_overflow", i), int'(out_overflow), int'(vecs[i].e_ovf));
            consume();
            chk($sformatf("v%0d_release", i), int'(out_valid), 0);
        end

        // Backpressure: hold the result while a new request is offered
        request(vecs[1], lat);
        chk("bp_latency", lat, 3);
        mode     = MODE_JULIA;
        pixel_r  = 8'd10;
        max_iter = 8'd1;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d", c),
                int'({out_valid, in_ready, out_iter, out_escaped, out_overflow}),
                int'({1'b1, 1'b0, 8'd2, 1'b1, 1'b1}));
        end
        in_valid = 1'b0;
        consume();
        chk("bp_drop_valid", int'(out_valid), 0);
        chk("bp_in_ready", int'(in_ready), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_ghost", int'(out_valid), 0);

        // Reset mid-RUN during an (0,0) run; previous outputs were iter 2, escaped, overflow
        mode     = vecs[0].mode;
        pixel_r  = vecs[0].pr;
        pixel_i  = vecs[0].pi;
        max_iter = vecs[0].mi;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_out_iter", int'(out_iter), 0);
        chk("rst_out_flags", int'({out_valid, out_escaped, out_overflow}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_no_result", int'(out_valid), 0);
        request(vecs[1], lat);
        chk("post_rst_latency", lat, 3);
        chk("post_rst_iter", int'(out_iter), 2);
        chk("post_rst_flags", int'({out_escaped, out_overflow}), 3);
        consume();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
